// File: rtl/freq_pkg.sv
// Shared widths and state encodings for the frequency counter and its BCD converter.
package freq_pkg;

  localparam int CNT_W      = 27;
  localparam int BCD_DIGITS = 9;

  typedef enum logic [1:0] {
    WAIT_LOW,
    ARMED,
    COUNT,
    LATCH
  } win_state_t;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one bit per cycle, restartable at any time by start.
module bin2bcd_seq
  import freq_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 9
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int CNT_BITS = $clog2(BIN_W + 1);

  conv_state_t         state;
  logic [BIN_W-1:0]    shreg;
  logic [4*DIGITS-1:0] work;
  logic [4*DIGITS-1:0] work_adj;
  logic [CNT_BITS-1:0] shifts;

  always_comb begin
    work_adj = work;
    for (int d = 0; d < DIGITS; d++) begin
      if (work[4*d +: 4] >= 4'd5) begin
        work_adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
      end
    end
  end

  // The start cycle already shifts in the MSB (nothing to adjust yet), so the
  // result is ready one cycle after the final shift.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= CONV_IDLE;
      shreg  <= '0;
      work   <= '0;
      shifts <= '0;
      bcd    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg  <= bin << 1;
        work   <= {{(4*DIGITS-1){1'b0}}, bin[BIN_W-1]};
        shifts <= CNT_BITS'(1);
        state  <= (BIN_W == 1) ? CONV_DONE : CONV_SHIFT;
      end else begin
        case (state)
          CONV_SHIFT: begin
            work   <= {work_adj[4*DIGITS-2:0], shreg[BIN_W-1]};
            shreg  <= shreg << 1;
            shifts <= shifts + 1'b1;
            if (shifts == CNT_BITS'(BIN_W - 1)) begin
              state <= CONV_DONE;
            end
          end
          CONV_DONE: begin
            bcd   <= work;
            done  <= 1'b1;
            state <= CONV_IDLE;
          end
          default: state <= CONV_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/freq_counter.sv
// Gated edge counter: counts synchronized Sig_In rising edges over each Gate_Signal
// window, latches the result and hands it to a background BCD conversion.
module freq_counter #(
  parameter int CNT_W      = freq_pkg::CNT_W,
  parameter int BCD_DIGITS = freq_pkg::BCD_DIGITS
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Gate_Signal,
  input  logic                    Sig_In,
  output logic [CNT_W-1:0]        Freq_Value,
  output logic                    Freq_Valid,
  output logic                    Overflow,
  output logic [4*BCD_DIGITS-1:0] Freq_Bcd,
  output logic                    Bcd_Valid
);

  import freq_pkg::win_state_t;
  import freq_pkg::WAIT_LOW;
  import freq_pkg::ARMED;
  import freq_pkg::COUNT;
  import freq_pkg::LATCH;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  win_state_t       state;
  logic             sig_meta, sig_sync, sig_hist, gate_d;
  logic             edge_det, gate_rise, gate_fall;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat_flag;

  // Sig_In is the only asynchronous input; Gate_Signal just needs one delay for edge detection.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sig_meta <= 1'b0;
      sig_sync <= 1'b0;
      sig_hist <= 1'b0;
      gate_d   <= 1'b0;
    end else begin
      sig_meta <= Sig_In;
      sig_sync <= sig_meta;
      sig_hist <= sig_sync;
      gate_d   <= Gate_Signal;
    end
  end

  assign edge_det  = sig_sync & ~sig_hist;
  assign gate_rise = Gate_Signal & ~gate_d;
  assign gate_fall = ~Gate_Signal & gate_d;

  // WAIT_LOW keeps a window that was already open at reset release from being measured.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= WAIT_LOW;
      edge_cnt   <= '0;
      sat_flag   <= 1'b0;
      Freq_Value <= '0;
      Freq_Valid <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      Freq_Valid <= 1'b0;
      case (state)
        WAIT_LOW: if (!Gate_Signal) state <= ARMED;
        ARMED: begin
          if (gate_rise) begin
            state    <= COUNT;
            edge_cnt <= CNT_W'(edge_det);
            sat_flag <= 1'b0;
          end
        end
        COUNT: begin
          if (gate_fall) begin
            state <= LATCH;
          end else if (Gate_Signal && edge_det) begin
            if (edge_cnt == CNT_MAX) sat_flag <= 1'b1;
            else                     edge_cnt <= edge_cnt + 1'b1;
          end
        end
        LATCH: begin
          Freq_Value <= edge_cnt;
          Overflow   <= sat_flag;
          Freq_Valid <= 1'b1;
          state      <= ARMED;
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

  bin2bcd_seq #(
    .BIN_W  (CNT_W),
    .DIGITS (BCD_DIGITS)
  ) u_bcd (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .start (Freq_Valid),
    .bin   (Freq_Value),
    .bcd   (Freq_Bcd),
    .done  (Bcd_Valid)
  );

endmodule

// File: doc/freq_counter.md
FREQ_COUNTER -- requirements
Module: freq_counter

Interface
REQ-001 Parameter CNT_W, default 27, is the count and result width in bits.
REQ-002 Parameter BCD_DIGITS, default 9, is the number of BCD result digits.
REQ-003 Clk  input  1  is the single system clock, 100 MHz; all logic is on its rising edge.
REQ-004 Rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 Gate_Signal  input  1  is the measurement window, synchronous to Clk: high = count window (1 s), low = idle (1 s).
REQ-006 Sig_In  input  1  is the signal under test, asynchronous to Clk.
REQ-007 Freq_Value  output  CNT_W  is the binary edge count of the last completed window.
REQ-008 Freq_Valid  output  1  is a one-cycle pulse marking that Freq_Value has just updated.
REQ-009 Overflow  output  1  flags that the last completed window saturated the counter.
REQ-010 Freq_Bcd  output  4*BCD_DIGITS  is the BCD form of Freq_Value, least-significant digit in bits [3:0].
REQ-011 Bcd_Valid  output  1  is a one-cycle pulse marking that Freq_Bcd has just updated.

Function
REQ-012 Sig_In SHALL pass through a 2-flop synchronizer plus 1 history flop; an edge is counted when sync=1 and history=0.
REQ-013 Gate_Signal SHALL be registered once; rise = Gate_Signal & ~gate_d, fall = ~Gate_Signal & gate_d.
REQ-014 The window FSM SHALL have the states WAIT_LOW, ARMED, COUNT and LATCH.
REQ-015 WAIT_LOW -> ARMED on the first cycle with Gate_Signal=0, so a window already open at reset release is never measured.
REQ-016 ARMED -> COUNT on a gate rise; in that cycle the counter loads 1 if an edge is detected, else 0.
REQ-017 COUNT SHALL increment on each detected edge while Gate_Signal=1.
REQ-018 COUNT -> LATCH on a gate fall; an edge detected in the fall cycle is not counted.
REQ-019 In LATCH, for one cycle: Freq_Value <= count, Overflow <= saturation flag, Freq_Valid=1; then -> ARMED.
REQ-020 The counter SHALL saturate at 2^CNT_W-1 and set a sticky saturation flag, which clears at the next window start.
REQ-021 Latency: Freq_Valid SHALL assert 2 Clk cycles after Gate_Signal falls.
REQ-022 The BCD converter SHALL start on Freq_Valid and run a sequential double-dabble, one bit per cycle, for CNT_W cycles.
REQ-023 Bcd_Valid SHALL pulse in the cycle after the last shift, CNT_W+1 cycles after Freq_Valid, with Freq_Bcd updated in that same cycle.
REQ-024 Freq_Bcd SHALL hold its previous value during a conversion.
REQ-025 A Freq_Valid arriving while a conversion is in progress SHALL restart the conversion with the new value; the aborted result is never emitted.
REQ-026 Counting and conversion SHALL run concurrently; the converter never stalls the window FSM.

Reset
REQ-027 Rst_n=0 SHALL clear all of the following: synchronizer, history and gate_d flops; the counter; the saturation flag.
REQ-028 Rst_n=0 SHALL drive Freq_Value=0, Freq_Valid=0, Overflow=0, Freq_Bcd=0 and Bcd_Valid=0.
REQ-029 Rst_n=0 SHALL put the window FSM in WAIT_LOW and the converter in idle.
REQ-030 Reset asserted mid-window or mid-conversion SHALL discard the partial count and the partial conversion.

Structure
REQ-031 Shared package freq_pkg SHALL hold CNT_W, BCD_DIGITS and the window-FSM state encoding.
REQ-032 The converter SHALL be the sub-module bin2bcd_seq (start, bin in, bcd out, done), with its own idle/shift/done control.
REQ-033 Implementation target is 150-300 lines of RTL in total, with no clock-domain logic other than the Sig_In synchronizer.

Verification
REQ-034 Scenario: Gate high for 1000 cycles, Sig_In period 10 cycles -> Freq_Value=100, Overflow=0, Freq_Bcd=0x000000100, Bcd_Valid 28 cycles after Freq_Valid.
REQ-035 Scenario: Sig_In toggling every cycle (Clk/2), 1000-cycle window -> Freq_Value=500 (+/-1).
REQ-036 Scenario: CNT_W=8, BCD_DIGITS=3, 300 edges in the window -> Freq_Value=255, Overflow=1; next window with 10 edges -> 10, Overflow=0.
REQ-037 Scenario: Gate_Signal=1 at reset release -> no Freq_Valid for that window; the next full window is measured correctly.
REQ-038 Scenario: Rst_n pulsed low at window cycle 500 -> all outputs 0, no Freq_Valid for that window.
REQ-039 Scenario: second Freq_Valid forced 5 cycles into a conversion -> a single Bcd_Valid, carrying the second value.
